// File: rtl/branch_resolver_if.sv
// Handshake bundle between fetch (predictions), execute (resolutions) and the
// branch resolver (redirect/flush back to the front end).
//   master : fetch/execute side; drives pred_* and res_*, observes redirect.
//   slave  : the resolver; accepts pred_*/res_*, drives pred_ready, cancel,
//            flush, redirect_valid, redirect_pc.
interface branch_resolver_if #(
  parameter int ADDR_W = 32
);
  logic              pred_valid;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_pc;
  logic [ADDR_W-1:0] pred_target;
  logic              pred_ready;
  logic              res_valid;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              cancel;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, cancel, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, cancel, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: in-order queue of unresolved branch predictions checked
// against execute outcomes. A mispredict clears the queue and produces a
// one-cycle cancel/flush/redirect pulse (SQUASH state) the cycle after the
// resolution is sampled.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   bus (slave)    prediction input, resolution input, redirect outputs
//   inflight       queue occupancy
//   resolved_cnt   resolved branches (wraps)
//   mispred_cnt    mispredicted branches (wraps)
//   underflow_err  sticky: resolution arrived in RUN with an empty queue
module branch_resolver #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_resolver_if.slave         bus,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [31:0]              resolved_cnt,
  output logic [31:0]              mispred_cnt,
  output logic                     underflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t            state, state_next;
  logic              mem_taken  [DEPTH];
  logic [ADDR_W-1:0] mem_pc     [DEPTH];
  logic [ADDR_W-1:0] mem_target [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              ready, pop, push, mispredict;
  logic [ADDR_W-1:0] correct_pc;

  // Ready looks at the current count only; a same-cycle pop frees nothing.
  assign ready              = (state == RUN) && (count != CW'(DEPTH));
  assign bus.pred_ready     = ready;
  assign bus.cancel         = (state == SQUASH);
  assign bus.flush          = (state == SQUASH);
  assign bus.redirect_valid = (state == SQUASH);
  assign bus.redirect_pc    = redirect_pc_q;
  assign inflight           = count;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mispredict = 1'b0;
    push       = 1'b0;
    correct_pc = bus.res_taken ? bus.res_target : (mem_pc[head] + ADDR_W'(4));
    case (state)
      RUN: begin
        pop        = bus.res_valid && (count != '0);
        mispredict = pop && ((bus.res_taken != mem_taken[head]) ||
                             (bus.res_taken && (bus.res_target != mem_target[head])));
        // A mispredict discards the whole queue, including a same-cycle enqueue.
        push       = bus.pred_valid && ready && !mispredict;
        if (mispredict) state_next = SQUASH;
      end
      SQUASH: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_taken[tail]  <= bus.pred_taken;
      mem_pc[tail]     <= bus.pred_pc;
      mem_target[tail] <= bus.pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      redirect_pc_q <= '0;
      resolved_cnt  <= '0;
      mispred_cnt   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (mispredict) begin
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        redirect_pc_q <= correct_pc;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (pop)        resolved_cnt <= resolved_cnt + 32'd1;
      if (mispredict) mispred_cnt  <= mispred_cnt + 32'd1;
      if ((state == RUN) && bus.res_valid && (count == '0)) underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
  logic        clk;
  logic        rst;
  logic [2:0]  inflight;
  logic [31:0] resolved_cnt;
  logic [31:0] mispred_cnt;
  logic        underflow_err;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } ent_t;

  branch_resolver_if #(.ADDR_W(32)) bus ();

  branch_resolver #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .inflight     (inflight),
    .resolved_cnt (resolved_cnt),
    .mispred_cnt  (mispred_cnt),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled at that point too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pred_valid  = 1'b0;
    bus.pred_taken  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_target = '0;
    bus.res_valid   = 1'b0;
    bus.res_taken   = 1'b0;
    bus.res_target  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic enq(input logic taken, input logic [31:0] pc, input logic [31:0] target);
    bus.pred_valid  = 1'b1;
    bus.pred_taken  = taken;
    bus.pred_pc     = pc;
    bus.pred_target = target;
    step();
    bus.pred_valid  = 1'b0;
  endtask

  task automatic res(input logic taken, input logic [31:0] target);
    bus.res_valid  = 1'b1;
    bus.res_taken  = taken;
    bus.res_target = target;
    step();
    bus.res_valid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.pred_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pred_ready: got %b expected 1", bus.pred_ready); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    n_checks++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected 0", bus.redirect_pc); end
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", underflow_err); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({bus.cancel, bus.flush, bus.redirect_valid} !== 3'b000) begin
        n_fail++; $display("FAIL idle_pulses cycle %0d: got %b expected 000", i, {bus.cancel, bus.flush, bus.redirect_valid});
      end
      n_checks++;
      if ({resolved_cnt, mispred_cnt} !== 64'h0) begin
        n_fail++; $display("FAIL idle_counters cycle %0d: got %h/%h expected 0/0", i, resolved_cnt, mispred_cnt);
      end
    end
  endtask

  task automatic test_correct();
    do_reset();
    enq(1'b1, 32'h100, 32'h200);
    enq(1'b0, 32'h104, 32'h0);
    n_checks++; if (inflight !== 3'd2) begin n_fail++; $display("FAIL correct_inflight2: got %0d expected 2", inflight); end
    res(1'b1, 32'h200);
    n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL correct_cancel1: got %b expected 0", bus.cancel); end
    res(1'b0, 32'hDEAD_BEEF);
    n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL correct_cancel2: got %b expected 0", bus.cancel); end
    n_checks++; if (resolved_cnt !== 32'd2) begin n_fail++; $display("FAIL correct_resolved: got %0d expected 2", resolved_cnt); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL correct_mispred: got %0d expected 0", mispred_cnt); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL correct_inflight0: got %0d expected 0", inflight); end
  endtask

  task automatic test_dir_mispredict();
    do_reset();
    enq(1'b1, 32'h100, 32'h200);
    enq(1'b0, 32'h108, 32'h0);
    enq(1'b1, 32'h10C, 32'h300);
    res(1'b0, 32'h0);
    n_checks++; if ({bus.cancel, bus.flush, bus.redirect_valid} !== 3'b111) begin n_fail++; $display("FAIL dir_pulses: got %b expected 111", {bus.cancel, bus.flush, bus.redirect_valid}); end
    n_checks++; if (bus.redirect_pc !== 32'h104) begin n_fail++; $display("FAIL dir_redirect_pc: got %h expected 104", bus.redirect_pc); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL dir_inflight: got %0d expected 0", inflight); end
    n_checks++; if (bus.pred_ready !== 1'b0) begin n_fail++; $display("FAIL dir_pred_ready_squash: got %b expected 0", bus.pred_ready); end
    n_checks++; if (mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL dir_mispred: got %0d expected 1", mispred_cnt); end
    n_checks++; if (resolved_cnt !== 32'd1) begin n_fail++; $display("FAIL dir_resolved: got %0d expected 1", resolved_cnt); end
    step();
    n_checks++; if ({bus.cancel, bus.flush, bus.redirect_valid} !== 3'b000) begin n_fail++; $display("FAIL dir_pulse_width: got %b expected 000", {bus.cancel, bus.flush, bus.redirect_valid}); end
    n_checks++; if (bus.pred_ready !== 1'b1) begin n_fail++; $display("FAIL dir_pred_ready_after: got %b expected 1", bus.pred_ready); end
  endtask

  task automatic test_target_mispredict();
    do_reset();
    enq(1'b1, 32'h40, 32'h80);
    res(1'b1, 32'h90);
    n_checks++; if (bus.cancel !== 1'b1) begin n_fail++; $display("FAIL tgt_cancel: got %b expected 1", bus.cancel); end
    n_checks++; if (bus.redirect_pc !== 32'h90) begin n_fail++; $display("FAIL tgt_redirect_pc: got %h expected 90", bus.redirect_pc); end
    step();
    n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL tgt_cancel_width: got %b expected 0", bus.cancel); end
    n_checks++; if (mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL tgt_mispred: got %0d expected 1", mispred_cnt); end
  endtask

  task automatic test_back_to_back();
    // Resolution in the very cycle after enqueue.
    do_reset();
    enq(1'b1, 32'h300, 32'h380);
    res(1'b1, 32'h380);
    n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL b2b_cancel: got %b expected 0", bus.cancel); end
    n_checks++; if (resolved_cnt !== 32'd1) begin n_fail++; $display("FAIL b2b_resolved: got %0d expected 1", resolved_cnt); end
  endtask

  task automatic test_full_wrap();
    ent_t q[$];
    ent_t e;
    ent_t h;
    logic exp_ready;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      e.taken = n[0]; e.pc = 32'h1000 + 32'(4 * n); e.target = 32'h2000 + 32'(16 * n);
      enq(e.taken, e.pc, e.target);
      q.push_back(e);
    end
    n_checks++; if (bus.pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_pred_ready: got %b expected 0", bus.pred_ready); end
    n_checks++; if (inflight !== 3'd4) begin n_fail++; $display("FAIL full_inflight: got %0d expected 4", inflight); end
    enq(1'b1, 32'hDEAD, 32'hBEEF);
    n_checks++; if (inflight !== 3'd4) begin n_fail++; $display("FAIL full_drop_inflight: got %0d expected 4", inflight); end
    for (int k = 0; k < 10; k++) begin
      int n;
      n = 4 + k;
      exp_ready = (q.size() != 4);
      n_checks++; if (bus.pred_ready !== exp_ready) begin n_fail++; $display("FAIL wrap_pred_ready cycle %0d: got %b expected %b", k, bus.pred_ready, exp_ready); end
      e.taken = n[0]; e.pc = 32'h1000 + 32'(4 * n); e.target = 32'h2000 + 32'(16 * n);
      h = q.pop_front();
      bus.pred_valid = 1'b1; bus.pred_taken = e.taken; bus.pred_pc = e.pc; bus.pred_target = e.target;
      bus.res_valid = 1'b1; bus.res_taken = h.taken;
      bus.res_target = h.taken ? h.target : 32'hFFFF_FFFF;
      step();
      if (exp_ready) q.push_back(e);
      n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL wrap_cancel cycle %0d: got %b expected 0", k, bus.cancel); end
      n_checks++; if (inflight !== 3'(q.size())) begin n_fail++; $display("FAIL wrap_inflight cycle %0d: got %0d expected %0d", k, inflight, q.size()); end
    end
    idle_inputs();
    n_checks++; if (resolved_cnt !== 32'd10) begin n_fail++; $display("FAIL wrap_resolved: got %0d expected 10", resolved_cnt); end
    while (q.size() > 0) begin
      h = q.pop_front();
      res(h.taken, h.target);
      n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL drain_cancel pc %h: got %b expected 0", h.pc, bus.cancel); end
    end
    n_checks++; if (resolved_cnt !== 32'd13) begin n_fail++; $display("FAIL drain_resolved: got %0d expected 13", resolved_cnt); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL drain_mispred: got %0d expected 0", mispred_cnt); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL drain_inflight: got %0d expected 0", inflight); end
  endtask

  task automatic test_underflow();
    do_reset();
    res(1'b1, 32'h0);
    n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b expected 1", underflow_err); end
    n_checks++; if (resolved_cnt !== 32'd0) begin n_fail++; $display("FAIL underflow_resolved: got %0d expected 0", resolved_cnt); end
    n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL underflow_cancel: got %b expected 0", bus.cancel); end
    step();
    step();
    n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b expected 1", underflow_err); end
  endtask

  task automatic test_squash_ignore();
    do_reset();
    enq(1'b1, 32'h500, 32'h600);
    enq(1'b0, 32'h504, 32'h0);
    res(1'b0, 32'h0);
    n_checks++; if (bus.cancel !== 1'b1) begin n_fail++; $display("FAIL squash_cancel: got %b expected 1", bus.cancel); end
    // Wrong-path resolution and a new prediction during SQUASH.
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 32'h700;
    bus.pred_valid = 1'b1; bus.pred_taken = 1'b1; bus.pred_pc = 32'h700; bus.pred_target = 32'h800;
    step();
    idle_inputs();
    n_checks++; if (resolved_cnt !== 32'd1) begin n_fail++; $display("FAIL squash_resolved: got %0d expected 1", resolved_cnt); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL squash_inflight: got %0d expected 0", inflight); end
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL squash_underflow: got %b expected 0", underflow_err); end
    n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL squash_cancel_width: got %b expected 0", bus.cancel); end
    n_checks++; if (bus.redirect_pc !== 32'h504) begin n_fail++; $display("FAIL squash_redirect_hold: got %h expected 504", bus.redirect_pc); end
  endtask

  task automatic test_reset_during_cancel();
    do_reset();
    enq(1'b1, 32'h40, 32'h80);
    res(1'b0, 32'h0);
    n_checks++; if (bus.cancel !== 1'b1) begin n_fail++; $display("FAIL rstc_cancel: got %b expected 1", bus.cancel); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if ({bus.cancel, bus.flush, bus.redirect_valid} !== 3'b000) begin n_fail++; $display("FAIL rstc_pulses: got %b expected 000", {bus.cancel, bus.flush, bus.redirect_valid}); end
    n_checks++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rstc_redirect_pc: got %h expected 0", bus.redirect_pc); end
    n_checks++; if ({resolved_cnt, mispred_cnt} !== 64'h0) begin n_fail++; $display("FAIL rstc_counters: got %h/%h expected 0/0", resolved_cnt, mispred_cnt); end
    n_checks++; if (bus.pred_ready !== 1'b1) begin n_fail++; $display("FAIL rstc_pred_ready: got %b expected 1", bus.pred_ready); end
    // Mispredicting resolution coincident with reset: the cancel is lost.
    enq(1'b1, 32'h40, 32'h80);
    bus.res_valid = 1'b1; bus.res_taken = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; idle_inputs();
    n_checks++; if (bus.cancel !== 1'b0) begin n_fail++; $display("FAIL rst_lost_cancel: got %b expected 0", bus.cancel); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_lost_mispred: got %0d expected 0", mispred_cnt); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL rst_lost_inflight: got %0d expected 0", inflight); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_target_mispredict();
    test_back_to_back();
    test_full_wrap();
    test_underflow();
    test_squash_ignore();
    test_reset_during_cancel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
